// File: rtl/onehot_sel_decoder.sv
// Consumer of the rotating one-hot row-select token. It encodes the token to a row index, checks
// its integrity, counts passes and queues indices. Build option: SEL_DEC_MULTIHOT_CHECK_EN.
module onehot_sel_decoder #(
  parameter int unsigned N     = 280,
  parameter int unsigned IDXW  = 9,
  parameter int unsigned PASSW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     sel_in,
  input  logic             sel_valid,
  input  logic             clr_err,
  output logic [IDXW-1:0]  idx_out,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic [PASSW-1:0] pass_cnt,
  output logic             locked,
  output logic             err_zero,
  output logic             err_multi,
  output logic             err_seq,
  output logic             err_ovf
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  localparam logic [IDXW-1:0] LastIdx = IDXW'(N - 1);

  // Stage 1: sampled token
  logic [N-1:0] s1_vec_q;
  logic         s1_valid_q;

  // Stage 2: classification of the sampled token
  logic [IDXW-1:0] s2_idx;
  logic [IDXW-1:0] s2_next_exp;
  logic            s2_zero;
  logic            s2_multi;
  logic            s2_good;

  // Tracker
  state_e           state_q, state_d;
  logic [IDXW-1:0]  expected_q, expected_d;
  logic [PASSW-1:0] pass_q, pass_d;
  logic             push;
  logic             ev_zero;
  logic             ev_seq;

  // Output buffer
  logic [1:0]      count_q, count_d;
  logic [IDXW-1:0] head_q, head_d;
  logic [IDXW-1:0] tail_q, tail_d;
  logic            pop;
  logic            ev_ovf;

  // Sticky flags
  logic err_zero_q, err_zero_d;
  logic err_seq_q, err_seq_d;
  logic err_ovf_q, err_ovf_d;

  // OR-tree encoder: a multi-hot vector yields the OR of its set-bit positions.
  always_comb begin
    s2_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (s1_vec_q[i]) begin
        s2_idx = s2_idx | IDXW'(i);
      end
    end
  end

  assign s2_zero = ~|s1_vec_q;

`ifdef SEL_DEC_MULTIHOT_CHECK_EN
  logic [IDXW:0] s2_ones;
  logic          ev_multi;
  logic          err_multi_q, err_multi_d;

  always_comb begin
    s2_ones = '0;
    for (int unsigned i = 0; i < N; i++) begin
      s2_ones = s2_ones + {{IDXW{1'b0}}, s1_vec_q[i]};
    end
  end

  assign s2_multi = (s2_ones > (IDXW + 1)'(1));
`else
  assign s2_multi = 1'b0;
`endif

  assign s2_good = ~s2_zero & ~s2_multi;

  // Multi-hot ORs can exceed N-1 when the check is disabled; treat them as the wrap point.
  assign s2_next_exp = (s2_idx >= LastIdx) ? '0 : s2_idx + 1'b1;

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    pass_d     = pass_q;
    push       = 1'b0;
    ev_zero    = 1'b0;
    ev_seq     = 1'b0;
`ifdef SEL_DEC_MULTIHOT_CHECK_EN
    ev_multi   = 1'b0;
`endif
    if (s1_valid_q) begin
      if (!s2_good) begin
        ev_zero = s2_zero;
`ifdef SEL_DEC_MULTIHOT_CHECK_EN
        ev_multi = s2_multi;
`endif
        state_d = StIdle;
      end else begin
        push       = 1'b1;
        expected_d = s2_next_exp;
        state_d    = StLocked;
        if (state_q == StLocked) begin
          if (s2_idx != expected_q) begin
            ev_seq = 1'b1;
          end else if (s2_idx == '0 && pass_q != '1) begin
            // An in-sequence 0 can only follow N-1, so this closes a pass.
            pass_d = pass_q + 1'b1;
          end
        end
      end
    end
  end

  assign idx_valid = |count_q;
  assign pop       = idx_valid & idx_ready;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    ev_ovf  = 1'b0;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = s2_idx;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = s2_idx;
        end else if (push) begin
          tail_d  = s2_idx;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d = tail_q;
          if (push) begin
            tail_d = s2_idx;
          end else begin
            count_d = 2'd1;
          end
        end else if (push) begin
          ev_ovf = 1'b1;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  // A new event in the same cycle as clr_err leaves the flag set.
  always_comb begin
    err_zero_d = (clr_err ? 1'b0 : err_zero_q) | ev_zero;
    err_seq_d  = (clr_err ? 1'b0 : err_seq_q) | ev_seq;
    err_ovf_d  = (clr_err ? 1'b0 : err_ovf_q) | ev_ovf;
`ifdef SEL_DEC_MULTIHOT_CHECK_EN
    err_multi_d = (clr_err ? 1'b0 : err_multi_q) | ev_multi;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vec_q   <= '0;
      s1_valid_q <= 1'b0;
      state_q    <= StIdle;
      expected_q <= '0;
      pass_q     <= '0;
      count_q    <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      err_zero_q <= 1'b0;
      err_seq_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      s1_valid_q <= sel_valid;
      if (sel_valid) begin
        s1_vec_q <= sel_in;
      end
      state_q    <= state_d;
      expected_q <= expected_d;
      pass_q     <= pass_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      err_zero_q <= err_zero_d;
      err_seq_q  <= err_seq_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

`ifdef SEL_DEC_MULTIHOT_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_multi_q <= 1'b0;
    end else begin
      err_multi_q <= err_multi_d;
    end
  end

  assign err_multi = err_multi_q;
`else
  assign err_multi = 1'b0;
`endif

  assign idx_out  = head_q;
  assign pass_cnt = pass_q;
  assign locked   = (state_q == StLocked);
  assign err_zero = err_zero_q;
  assign err_seq  = err_seq_q;
  assign err_ovf  = err_ovf_q;

endmodule

// File: tb/tb_onehot_sel_decoder.sv
// Directed bench for onehot_sel_decoder: walks, pass wrap, sequence/zero/multi errors,
// backpressure overflow and mid-stream reset.
module tb_onehot_sel_decoder;

  localparam int unsigned N     = 280;
  localparam int unsigned IDXW  = 9;
  localparam int unsigned PASSW = 16;

  logic             clk;
  logic             rst;
  logic [N-1:0]     sel_in;
  logic             sel_valid;
  logic             clr_err;
  logic [IDXW-1:0]  idx_out;
  logic             idx_valid;
  logic             idx_ready;
  logic [PASSW-1:0] pass_cnt;
  logic             locked;
  logic             err_zero;
  logic             err_multi;
  logic             err_seq;
  logic             err_ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  onehot_sel_decoder #(
    .N     (N),
    .IDXW  (IDXW),
    .PASSW (PASSW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sel_in    (sel_in),
    .sel_valid (sel_valid),
    .clr_err   (clr_err),
    .idx_out   (idx_out),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .pass_cnt  (pass_cnt),
    .locked    (locked),
    .err_zero  (err_zero),
    .err_multi (err_multi),
    .err_seq   (err_seq),
    .err_ovf   (err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_tok(input int t);
    sel_in    = '0;
    sel_in[t] = 1'b1;
    sel_valid = 1'b1;
  endtask

  task automatic chk_flags(input string tag, input int z, input int m, input int s, input int o);
    chk({tag, "_zero"}, int'(err_zero), z);
    chk({tag, "_multi"}, int'(err_multi), m);
    chk({tag, "_seq"}, int'(err_seq), s);
    chk({tag, "_ovf"}, int'(err_ovf), o);
  endtask

  // Clean walk with ready=1: each index appears two edges after it is sampled.
  task automatic walk(input int start, input int cnt);
    for (int j = 0; j < cnt; j++) begin
      drive_tok((start + j) % N);
      tick();
      if (j == 0) begin
        chk("walk_lat", int'(idx_valid), 0);
      end else begin
        chk("walk_idx", int'(idx_out), (start + j - 1) % N);
        chk("walk_vld", int'(idx_valid), 1);
        chk("walk_lock", int'(locked), 1);
      end
    end
  endtask

  task automatic drain(input int last);
    sel_valid = 1'b0;
    tick();
    chk("drain_idx", int'(idx_out), last);
    chk("drain_vld", int'(idx_valid), 1);
    tick();
    chk("drain_empty", int'(idx_valid), 0);
  endtask

  initial begin
    rst       = 1'b0;
    sel_in    = '0;
    sel_valid = 1'b0;
    clr_err   = 1'b0;
    idx_ready = 1'b1;
    tick();
    tick();
    chk("rst_vld", int'(idx_valid), 0);
    chk("rst_idx", int'(idx_out), 0);
    chk("rst_pass", int'(pass_cnt), 0);
    chk("rst_lock", int'(locked), 0);
    chk_flags("rst", 0, 0, 0, 0);
    rst = 1'b1;

    // First full pass plus the wrapping 0
    walk(0, N + 1);
    drain(0);
    chk("pass1", int'(pass_cnt), 1);
    chk("pass1_lock", int'(locked), 1);
    chk_flags("pass1", 0, 0, 0, 0);

    // Second pass: 1..N-1 then 0
    walk(1, N);
    drain(0);
    chk("pass2", int'(pass_cnt), 2);
    chk_flags("pass2", 0, 0, 0, 0);

    // Sequence break: 1..7 clean, then 20, 21
    walk(1, 7);
    drain(7);
    chk("seq_pre", int'(err_seq), 0);
    drive_tok(20);
    tick();
    drive_tok(21);
    tick();
    chk("seq_idx20", int'(idx_out), 20);
    chk("seq_set", int'(err_seq), 1);
    chk("seq_lock", int'(locked), 1);
    sel_valid = 1'b0;
    clr_err   = 1'b1;
    tick();
    chk("seq_idx21", int'(idx_out), 21);
    chk("seq_clr", int'(err_seq), 0);
    clr_err = 1'b0;
    tick();
    chk("seq_pop", int'(idx_valid), 0);

    // Zero-hot while locked; clr_err on the same edge must lose to the new event
    sel_in    = '0;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    clr_err   = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("zero_flag", int'(err_zero), 1);
    chk("zero_lock", int'(locked), 0);
    chk("zero_vld", int'(idx_valid), 0);
    chk("zero_pass", int'(pass_cnt), 2);

    // Multi-hot bits 3 and 9
    sel_in    = '0;
    sel_in[3] = 1'b1;
    sel_in[9] = 1'b1;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    tick();
`ifdef SEL_DEC_MULTIHOT_CHECK_EN
    chk("multi_flag", int'(err_multi), 1);
    chk("multi_lock", int'(locked), 0);
    chk("multi_vld", int'(idx_valid), 0);
`else
    chk("multi_flag", int'(err_multi), 0);
    chk("multi_idx", int'(idx_out), 11);
    chk("multi_vld", int'(idx_valid), 1);
    chk("multi_lock", int'(locked), 1);
`endif
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk_flags("clr_all", 0, 0, 0, 0);

    // Backpressure: 10, 11 fill the buffer, 12 overflows
    idx_ready = 1'b0;
    drive_tok(10);
    tick();
    drive_tok(11);
    tick();
    chk("bp_head10a", int'(idx_out), 10);
    chk("bp_vld", int'(idx_valid), 1);
    drive_tok(12);
    tick();
    chk("bp_ovf_pre", int'(err_ovf), 0);
    sel_valid = 1'b0;
    tick();
    chk("bp_ovf", int'(err_ovf), 1);
    chk("bp_head10b", int'(idx_out), 10);
    tick();
    chk("bp_stable", int'(idx_out), 10);
    chk("bp_stable_vld", int'(idx_valid), 1);
    idx_ready = 1'b1;
    tick();
    chk("bp_head11", int'(idx_out), 11);
    chk("bp_vld11", int'(idx_valid), 1);
    tick();
    chk("bp_empty", int'(idx_valid), 0);
    chk("bp_lock", int'(locked), 1);
    chk("bp_pass", int'(pass_cnt), 2);
`ifdef SEL_DEC_MULTIHOT_CHECK_EN
    chk("bp_seq", int'(err_seq), 0);
`else
    chk("bp_seq", int'(err_seq), 1);
`endif

    // Reset mid-stream: buffer full, locked, token 15 in stage 1
    idx_ready = 1'b0;
    drive_tok(13);
    tick();
    drive_tok(14);
    tick();
    drive_tok(15);
    tick();
    chk("mid_head", int'(idx_out), 13);
    chk("mid_lock", int'(locked), 1);
    rst       = 1'b0;
    sel_valid = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_vld", int'(idx_valid), 0);
    chk("mid_idx", int'(idx_out), 0);
    chk("mid_pass", int'(pass_cnt), 0);
    chk("mid_unlock", int'(locked), 0);
    chk_flags("mid", 0, 0, 0, 0);
    tick();
    chk("mid_discard", int'(idx_valid), 0);
    chk("mid_idle", int'(locked), 0);
    idx_ready = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot_sel_decoder.md
Name: onehot_sel_decoder

Overview:
- Consumer side of the rotating one-hot row-select token used by the row-wise datapath.
- Samples the N-bit one-hot select vector, encodes it to a binary row index and checks token integrity (zero-hot, multi-hot, out-of-sequence).
- Counts completed token passes and delivers indices to downstream PE bookkeeping through a 2-entry valid/ready buffer.
- The token source free-runs and has no backpressure, so overflow is detected and flagged, never stalled.

Parameters:
N, 280, width of the one-hot select vector (number of rows).
IDXW, 9, index width; must satisfy 2**IDXW >= N.
PASSW, 16, width of the pass counter.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  reset, synchronous, active-low.
sel_in  in  N  one-hot row-select vector.
sel_valid  in  1  sel_in holds a new token position this cycle.
clr_err  in  1  synchronous clear of all sticky flags.
idx_out  out  IDXW  encoded row index at buffer head.
idx_valid  out  1  idx_out valid.
idx_ready  in  1  downstream accepts idx_out when high together with idx_valid.
pass_cnt  out  PASSW  completed passes (wrap N-1 -> 0), saturating.
locked  out  1  tracker in LOCKED state.
err_zero  out  1  sticky: sampled vector had no bit set.
err_multi  out  1  sticky: sampled vector had more than one bit set.
err_seq  out  1  sticky: index not equal to expected (prev+1 mod N) while LOCKED.
err_ovf  out  1  sticky: valid index dropped because the buffer was full.

Behaviour:
- Reset (rst=0 at clk edge):
  - All state cleared; the clock edge with rst=0 overrides every other input.
  - Buffer empty, idx_valid=0, idx_out=0, pass_cnt=0, locked=0, all err_* = 0, tracker in IDLE.
  - Reset mid-operation discards pipeline and buffer contents.
- Stage 1, cycle k: when sel_valid=1, register sel_in and a valid bit. When sel_valid=0, the stage-1 valid bit clears.
- Stage 2, cycle k+1:
  - Encode to an index using an OR-tree over bit positions.
  - Compute zero = ~|vec and multi = (popcount > 1).
  - Classify the sample as good (not zero, not multi) or bad.
- Tracker FSM, evaluated on each stage-2 valid sample:
  - IDLE, good sample: expected <= (idx+1) mod N, go to LOCKED, push idx.
  - IDLE, bad sample: set the matching err flag, stay in IDLE, no push.
  - LOCKED, good sample with idx == expected: push idx, expected <= (idx+1) mod N.
    - If idx == 0 and the previous idx was N-1, pass_cnt <= pass_cnt+1, saturating at 2**PASSW-1.
  - LOCKED, good sample with idx != expected: set err_seq, push idx, re-seed expected <= (idx+1) mod N, stay in LOCKED, no pass increment.
  - LOCKED, bad sample: set err_zero or err_multi, go to IDLE, no push.
- Expected wrap: idx == N-1 gives expected 0. Indices >= N cannot occur from a one-hot vector of width N.
- Buffer: 2-entry FIFO.
  - A push becomes visible on idx_out/idx_valid at the edge ending cycle k+1, so latency is 2 edges from sel_valid sample to idx_valid when the buffer is empty.
  - Pop on idx_valid & idx_ready.
  - Simultaneous push and pop with the buffer full: accepted, occupancy stays 2, no overflow.
  - Push with the buffer full and no pop: index dropped, err_ovf <= 1. Tracker and pass_cnt still update as if pushed.
  - idx_out/idx_valid are stable while idx_valid=1 and idx_ready=0.
- Sticky flags: clr_err=1 clears all err_* at that edge. If a new error event occurs in the same cycle, the new error wins (flag set). clr_err does not affect pass_cnt or locked.
- locked = (state == LOCKED), registered.

Optional Feature:
- Macro: SEL_DEC_MULTIHOT_CHECK_EN.
- Defined: popcount logic present. Multi-hot samples are classified bad, set err_multi and return the tracker to IDLE.
- Undefined: no popcount logic and err_multi is tied 0. A multi-hot vector is treated as good, with index = bitwise OR of the set-bit indices, and it enters normal sequence checking (usually raising err_seq).

Test Plan:
- Reset then one-hot walk: rst=0 for 2 cycles, then sel_in=1<<0, 1<<1, ... with sel_valid=1 every cycle and idx_ready=1 -> idx_out 0,1,2,... each appearing 2 edges after its sample; locked=1 after the first; no errors.
- Full pass wrap: walk 0..279 then 0, ready=1 -> pass_cnt=1 after the index 0 that follows 279; a second full pass -> pass_cnt=2.
- Sequence break: walk 5,6,7 then inject 1<<20 -> err_seq=1, idx 20 still delivered, next 21 accepted without a new error; pulse clr_err -> err_seq=0.
- Zero/multi-hot: while locked, inject sel_in=0 -> err_zero=1, locked=0, no output; inject bits 3 and 9 -> err_multi=1 with macro defined, err_multi=0 and idx_out=11 without it.
- Backpressure: idx_ready=0, push 3 consecutive good tokens 10,11,12 -> buffer holds 10,11, err_ovf=1; raise ready -> outputs 10 then 11; pass/lock tracking unaffected.
- Reset mid-stream: buffer holding 2 entries and locked, assert rst=0 for one edge -> idx_valid=0, pass_cnt=0, locked=0, all flags 0 on the next cycle.
